// File: rtl/noc_mem_pkg.sv
// Shared types and packet field layout for the remote-memory responder.
package noc_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ_REQ  = 2'b00,
        OP_WRITE_REQ = 2'b01,
        OP_READ_RESP = 2'b10,
        OP_WRITE_ACK = 2'b11
    } opcodeT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_RD_WAIT = 2'd2
    } stateT;

    // Collector request format (72 bits) and response format (68 bits)
    // share the opcode, address and data positions.
    localparam int REQ_WIDTH  = 72;
    localparam int RESP_WIDTH = 68;
    localparam int OP_LSB     = 66;
    localparam int OP_WIDTH   = 2;
    localparam int ERR_BIT    = 65;
    localparam int ADDR_LSB   = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_LSB   = 0;
    localparam int DATA_WIDTH = 32;

    function automatic logic [RESP_WIDTH-1:0] makeResp(
        input opcodeT                op,
        input logic                  err,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [RESP_WIDTH-1:0] pkt;
        pkt = '0;
        pkt[OP_LSB +: OP_WIDTH]     = op;
        pkt[ERR_BIT]                = err;
        pkt[ADDR_LSB +: ADDR_WIDTH] = addr;
        pkt[DATA_LSB +: DATA_WIDTH] = data;
        return pkt;
    endfunction

endpackage

// File: rtl/noc_mem_responder_resp_fifo.sv
// Response queue: synchronous FIFO with occupancy count, empty and full.
module resp_fifo #(
    parameter int  WIDTH = 77,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap on power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_mem_responder.sv
// Remote-memory responder: services read/write requests against this node's
// RAM chunk and queues one tagged response per legal request.
//
// state      | meaning
// ST_IDLE    | waiting for a request; accepts while the response FIFO has room
// ST_EXEC    | RAM address/write cycle; writes and range errors respond here
// ST_RD_WAIT | RAM read data present; read response is pushed
module noc_mem_responder
    import noc_mem_pkg::*;
#(
    parameter int  NODE_ID         = 0,
    parameter int  NODE_COUNT      = 9,
    parameter int  RAM_CHUNK_SIZE  = 1024,
    parameter int  PACKET_ID_WIDTH = 5,
    parameter int  QUEUE_DEPTH     = 4,
    localparam int NW              = $clog2(NODE_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_WIDTH-1:0]       packet_in,
    input  logic [NW-1:0]              node_start,
    input  logic [PACKET_ID_WIDTH-1:0] packet_id_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [31:0]                ram_address,
    output logic [31:0]                wr_data,
    output logic                       we,
    input  logic [31:0]                rd_data,
    output logic [RESP_WIDTH-1:0]      packet_out,
    output logic [NW-1:0]              node_dest,
    output logic [PACKET_ID_WIDTH-1:0] packet_id_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [7:0]                 err_count
);
    localparam logic [31:0] CHUNK_BASE  = 32'(NODE_ID * RAM_CHUNK_SIZE);
    localparam logic [31:0] CHUNK_LIMIT = 32'((NODE_ID + 1) * RAM_CHUNK_SIZE);
    localparam int          ENTRY_WIDTH = RESP_WIDTH + NW + PACKET_ID_WIDTH;
    localparam int          CW          = $clog2(QUEUE_DEPTH) + 1;

    stateT                      state;
    opcodeT                     reqOp;
    logic [31:0]                reqAddr;
    logic [31:0]                reqData;
    logic [NW-1:0]              reqNode;
    logic [PACKET_ID_WIDTH-1:0] reqId;
    logic                       reqInRange;
    logic [7:0]                 errCountQ;
    logic [31:0]                ramAddrQ;
    logic [31:0]                wrDataQ;
    logic                       weQ;

    opcodeT                     opIn;
    logic [31:0]                addrIn;
    logic [31:0]                dataIn;
    logic                       inRangeIn;
    logic                       accept;

    logic                       pushEn;
    opcodeT                     pushOp;
    logic                       pushErr;
    logic [31:0]                pushData;
    logic [ENTRY_WIDTH-1:0]     pushWord;
    logic [ENTRY_WIDTH-1:0]     fifoHead;
    logic [ENTRY_WIDTH-1:0]     headWord;
    logic [CW-1:0]              fifoCount;
    logic                       fifoEmpty;
    logic                       fifoFull;
    logic                       unusedBits;

    assign opIn       = opcodeT'(packet_in[OP_LSB +: OP_WIDTH]);
    assign addrIn     = packet_in[ADDR_LSB +: ADDR_WIDTH];
    assign dataIn     = packet_in[DATA_LSB +: DATA_WIDTH];
    assign inRangeIn  = (addrIn >= CHUNK_BASE) && (addrIn < CHUNK_LIMIT);
    assign ready_out  = (state == ST_IDLE) && !fifoFull;
    assign accept     = valid_in && ready_out;
    assign unusedBits = ^{packet_in[71:68], packet_in[64], fifoCount};

    // Request sequencing, request capture, error counter and registered RAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            reqOp      <= OP_READ_REQ;
            reqAddr    <= '0;
            reqData    <= '0;
            reqNode    <= '0;
            reqId      <= '0;
            reqInRange <= 1'b0;
            errCountQ  <= '0;
            ramAddrQ   <= '0;
            wrDataQ    <= '0;
            weQ        <= 1'b0;
        end else begin
            ramAddrQ <= '0;
            wrDataQ  <= '0;
            weQ      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        reqOp      <= opIn;
                        reqAddr    <= addrIn;
                        reqData    <= dataIn;
                        reqNode    <= node_start;
                        reqId      <= packet_id_in;
                        reqInRange <= inRangeIn;
                        if (opIn == OP_READ_RESP || opIn == OP_WRITE_ACK) begin
                            if (errCountQ != 8'hFF) errCountQ <= errCountQ + 8'd1;
                        end else begin
                            state <= ST_EXEC;
                            // RAM port is set up at accept so it is live during EXEC.
                            if (inRangeIn) begin
                                ramAddrQ <= addrIn - CHUNK_BASE;
                                if (opIn == OP_WRITE_REQ) begin
                                    weQ     <= 1'b1;
                                    wrDataQ <= dataIn;
                                end
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    state <= (reqOp == OP_READ_REQ && reqInRange) ? ST_RD_WAIT : ST_IDLE;
                end
                ST_RD_WAIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response generation: range errors and write acks from EXEC, read data from RD_WAIT.
    always_comb begin
        pushEn   = 1'b0;
        pushOp   = OP_READ_RESP;
        pushErr  = 1'b0;
        pushData = '0;
        case (state)
            ST_EXEC: begin
                pushOp = (reqOp == OP_WRITE_REQ) ? OP_WRITE_ACK : OP_READ_RESP;
                if (!reqInRange) begin
                    pushEn  = 1'b1;
                    pushErr = 1'b1;
                end else if (reqOp == OP_WRITE_REQ) begin
                    pushEn   = 1'b1;
                    pushData = reqData;
                end
            end
            ST_RD_WAIT: begin
                pushEn   = 1'b1;
                pushData = rd_data;
            end
            default: begin
                pushEn = 1'b0;
            end
        endcase
    end

    assign pushWord = {makeResp(pushOp, pushErr, reqAddr, pushData), reqNode, reqId};

    resp_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) uRespFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushEn),
        .pushData (pushWord),
        .pop      (ready_in),
        .headData (fifoHead),
        .count    (fifoCount),
        .empty    (fifoEmpty),
        .full     (fifoFull)
    );

    // Stale storage behind an empty queue must not leak onto the outputs.
    assign headWord      = fifoEmpty ? '0 : fifoHead;
    assign valid_out     = !fifoEmpty;
    assign packet_out    = headWord[ENTRY_WIDTH-1 -: RESP_WIDTH];
    assign node_dest     = headWord[PACKET_ID_WIDTH +: NW];
    assign packet_id_out = headWord[PACKET_ID_WIDTH-1:0];

    assign ram_address = ramAddrQ;
    assign wr_data     = wrDataQ;
    assign we          = weQ;
    assign err_count   = errCountQ;

endmodule
